// File: rtl/stack_controller.sv
// Hardware LIFO stack kept in an external data memory window starting at BASE.
// Latency: a push takes 2 cycles to the next ready; pop_valid comes 2 cycles after acceptance.
// Backpressure: ready is high only in IDLE; requests made while busy are dropped, not queued.
module stack_controller #(
    parameter logic [9:0] BASE  = 10'd960,
    parameter int         DEPTH = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    input  logic        clr_err,
    output logic        ready,
    output logic        pop_valid,
    output logic [15:0] pop_data,
    output logic [6:0]  count,
    output logic        full,
    output logic        empty,
    output logic        overflow_err,
    output logic        underflow_err,
    output logic        conflict_err,
    output logic [9:0]  mem_address,
    output logic [15:0] mem_data_out,
    output logic        mem_WE,
    input  logic [15:0] mem_data_in
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [15:0] word_q, word_d;
    logic [15:0] pop_data_q, pop_data_d;
    logic        pop_valid_q, pop_valid_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        cfl_q, cfl_d;
    logic        is_full, is_empty;
    logic [6:0]  slot;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == 7'd0);

    // Keep the idle address inside the window when every slot is occupied.
    assign slot = is_full ? (DEPTH_C - 7'd1) : count_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = clr_err ? 1'b0 : ovf_q;
        unf_d       = clr_err ? 1'b0 : unf_q;
        cfl_d       = clr_err ? 1'b0 : cfl_q;

        case (state_q)
            IDLE: begin
                if (push && pop) begin
                    cfl_d = 1'b1;
                end else if (push) begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        word_d  = push_data;
                        state_d = PUSH;
                    end
                end else if (pop) begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        count_d = count_q - 7'd1;
                        state_d = POP;
                    end
                end
            end
            PUSH: begin
                if (!is_full) begin
                    count_d = count_q + 7'd1;
                end
                state_d = IDLE;
            end
            POP: begin
                pop_data_d  = mem_data_in;
                pop_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            count_q     <= 7'd0;
            word_q      <= 16'd0;
            pop_data_q  <= 16'd0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            cfl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_q      <= word_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            cfl_q       <= cfl_d;
        end
    end

    assign ready         = (state_q == IDLE);
    assign pop_valid     = pop_valid_q;
    assign pop_data      = pop_data_q;
    assign count         = count_q;
    assign full          = is_full;
    assign empty         = is_empty;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign conflict_err  = cfl_q;
    assign mem_address   = BASE + {3'b000, slot};
    assign mem_data_out  = word_q;
    // A reset edge must never commit the in-flight write.
    assign mem_WE        = (state_q == PUSH) && !RST;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a behavioural 1024x16 data memory.
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        rst, push, pop, clr_err;
    logic [15:0] push_data;
    logic        ready, pop_valid, full, empty;
    logic        overflow_err, underflow_err, conflict_err;
    logic [15:0] pop_data, mem_data_out, mem_data_in;
    logic [6:0]  count;
    logic [9:0]  mem_address;
    logic        mem_WE;

    logic [15:0] mem [0:1023];
    int          we_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          we_base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_WE === 1'b1) begin
            mem[mem_address] <= mem_data_out;
            we_cnt <= we_cnt + 1;
        end
    end
    assign mem_data_in = mem[mem_address];

    stack_controller dut (
        .CLK(clk), .RST(rst), .push(push), .pop(pop), .push_data(push_data),
        .clr_err(clr_err), .ready(ready), .pop_valid(pop_valid), .pop_data(pop_data),
        .count(count), .full(full), .empty(empty), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .conflict_err(conflict_err),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_WE(mem_WE),
        .mem_data_in(mem_data_in)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [15:0] d);
        push = 1'b1; push_data = d;
        step();
        push = 1'b0;
        step();
    endtask

    task automatic do_pop(input logic [15:0] exp, input string tag);
        pop = 1'b1;
        step();
        pop = 1'b0;
        step();
        chk({tag, "_valid"}, 32'(pop_valid), 32'd1);
        chk({tag, "_data"}, 32'(pop_data), 32'(exp));
        step();
        chk({tag, "_valid_once"}, 32'(pop_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = 16'd0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(mem_WE), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd960);
        chk("rst_popv", 32'(pop_valid), 32'd0);
        chk("rst_popd", 32'(pop_data), 32'd0);
        chk("rst_word", 32'(mem_data_out), 32'd0);
        chk("rst_errs", {29'd0, overflow_err, underflow_err, conflict_err}, 32'd0);
        chk("rst_no_we", 32'(we_cnt), 32'd0);

        // Single push then pop
        push = 1'b1; push_data = 16'hA5A5;
        step();
        push = 1'b0;
        chk("p1_ready", 32'(ready), 32'd0);
        chk("p1_we", 32'(mem_WE), 32'd1);
        chk("p1_addr", 32'(mem_address), 32'd960);
        chk("p1_dout", 32'(mem_data_out), 32'hA5A5);
        chk("p1_count0", 32'(count), 32'd0);
        step();
        chk("p1_count1", 32'(count), 32'd1);
        chk("p1_mem", 32'(mem[960]), 32'hA5A5);
        chk("p1_ready2", 32'(ready), 32'd1);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("o1_count", 32'(count), 32'd0);
        chk("o1_addr", 32'(mem_address), 32'd960);
        chk("o1_we", 32'(mem_WE), 32'd0);
        chk("o1_ready", 32'(ready), 32'd0);
        chk("o1_valid_early", 32'(pop_valid), 32'd0);
        step();
        chk("o1_valid", 32'(pop_valid), 32'd1);
        chk("o1_data", 32'(pop_data), 32'hA5A5);
        step();
        chk("o1_valid_once", 32'(pop_valid), 32'd0);
        chk("o1_hold", 32'(pop_data), 32'hA5A5);

        // Underflow
        we_base = we_cnt;
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("unf_flag", 32'(underflow_err), 32'd1);
        chk("unf_ready", 32'(ready), 32'd1);
        chk("unf_count", 32'(count), 32'd0);
        step();
        chk("unf_popv", 32'(pop_valid), 32'd0);
        chk("unf_no_we", 32'(we_cnt), 32'(we_base));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("unf_clr", 32'(underflow_err), 32'd0);

        // LIFO with a request held through the busy cycle
        push = 1'b1; push_data = 16'h1111;
        step();
        chk("h_busy", 32'(ready), 32'd0);
        push_data = 16'h2222;
        step();
        chk("h_count1", 32'(count), 32'd1);
        chk("h_ready", 32'(ready), 32'd1);
        chk("h_ignored", 32'(mem_data_out), 32'h1111);
        step();
        chk("h_accept_dout", 32'(mem_data_out), 32'h2222);
        chk("h_accept_addr", 32'(mem_address), 32'd961);
        push_data = 16'h3333;
        step(); step();
        push = 1'b0;
        step();
        chk("h_count3", 32'(count), 32'd3);
        chk("h_errs", {29'd0, overflow_err, underflow_err, conflict_err}, 32'd0);
        do_pop(16'h3333, "lifo0");
        do_pop(16'h2222, "lifo1");
        do_pop(16'h1111, "lifo2");
        chk("lifo_empty", 32'(empty), 32'd1);

        // Conflict
        do_push(16'h0BAD);
        we_base = we_cnt;
        push = 1'b1; pop = 1'b1;
        step();
        chk("cfl_flag", 32'(conflict_err), 32'd1);
        chk("cfl_count", 32'(count), 32'd1);
        chk("cfl_ready", 32'(ready), 32'd1);
        chk("cfl_we", 32'(mem_WE), 32'd0);
        clr_err = 1'b1;
        step();
        chk("cfl_new_wins", 32'(conflict_err), 32'd1);
        push = 1'b0; pop = 1'b0;
        step();
        clr_err = 1'b0;
        chk("cfl_clr", 32'(conflict_err), 32'd0);
        chk("cfl_no_we", 32'(we_cnt), 32'(we_base));
        do_pop(16'h0BAD, "cfl_pop");

        // Fill to full, then overflow
        for (int i = 1; i <= 64; i++) do_push(16'(i));
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd64);
        chk("full_addr", 32'(mem_address), 32'd1023);
        we_base = we_cnt;
        push = 1'b1; push_data = 16'hFFFF;
        step();
        push = 1'b0;
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_ready", 32'(ready), 32'd1);
        chk("ovf_count", 32'(count), 32'd64);
        step();
        chk("ovf_no_we", 32'(we_cnt), 32'(we_base));
        chk("ovf_mem", 32'(mem[1023]), 32'd64);
        do_pop(16'd64, "ovf_pop");
        chk("ovf_count63", 32'(count), 32'd63);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow_err), 32'd0);

        // Reset aborting a push aimed at slot 63
        push = 1'b1; push_data = 16'hBEEF;
        step();
        push = 1'b0;
        chk("ra_we_before", 32'(mem_WE), 32'd1);
        chk("ra_addr", 32'(mem_address), 32'd1023);
        we_base = we_cnt;
        rst = 1'b1;
        #1;
        chk("ra_we_gated", 32'(mem_WE), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("ra_no_we", 32'(we_cnt), 32'(we_base));
        chk("ra_mem", 32'(mem[1023]), 32'd64);
        chk("ra_count", 32'(count), 32'd0);
        chk("ra_ready", 32'(ready), 32'd1);

        // Reset aborting a pop
        do_push(16'h5555);
        pop = 1'b1;
        step();
        pop = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rp_popv", 32'(pop_valid), 32'd0);
        chk("rp_count", 32'(count), 32'd0);
        step();
        chk("rp_popv2", 32'(pop_valid), 32'd0);
        chk("rp_popd", 32'(pop_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
